hs_master_fsm: RTL and testbench

Upstream producer for the 4-phase req/ack byte link. Buffers bytes pushed by the local write port in a small FIFO and transfers them one at a time to the downstream slave FSM over `req`/`data_out`/`ack`. Tracks completed transfers and flags protocol stalls when the timeout feature is compiled in.

---
 rtl/hs_master_fsm.sv | 192 +++++++++++++++++++
 tb/tb_hs_master_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hs_master_fsm.sv
// hs_master_fsm -- producer side of the 4-phase req/ack byte link.
//
// Bytes pushed on the write port are buffered in a DEPTH-entry FIFO and sent
// one at a time to the slave: pop into data_out and raise req, wait for ack
// high, drop req, wait for ack low, then pulse done and bump xfer_cnt.
//
// Optional feature macro: HS_ACK_TIMEOUT_EN
//   defined   : REQ_HI gives up after TIMEOUT cycles without ack, drops the
//               byte and sets the sticky err flag.
//   undefined : REQ_HI waits forever, err is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    FIFO write port (write while full is dropped)
//   full, empty       FIFO occupancy flags
//   req, data_out     registered handshake request and byte to the slave
//   ack               handshake acknowledge from the slave
//   busy              FSM not in IDLE
//   done              one-cycle pulse per completed transfer
//   xfer_cnt          completed-transfer count, wraps at 255
//   err               sticky ack-timeout flag
module hs_master_fsm #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       req,
   output logic [7:0] data_out,
   input  logic       ack,
   output logic       busy,
   output logic       done,
   output logic [7:0] xfer_cnt,
   output logic       err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } state_t;

   state_t state, state_nxt;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          push, pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en && !full;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ------------------------------------------------------ handshake FSM
   logic       req_nxt, done_nxt;
   logic [7:0] data_nxt, cnt_nxt;
   logic       aborted;

`ifdef HS_ACK_TIMEOUT_EN
   logic [7:0] wait_cnt, wait_nxt;
   logic       aborted_r, aborted_nxt, err_nxt;
   assign aborted = aborted_r;
`else
   // No timeout: transfers can never be aborted and err never fires.
   assign aborted = 1'b0;
   assign err     = 1'b0;
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      req_nxt   = req;
      data_nxt  = data_out;
      done_nxt  = 1'b0;
      cnt_nxt   = xfer_cnt;
`ifdef HS_ACK_TIMEOUT_EN
      wait_nxt    = wait_cnt;
      aborted_nxt = aborted_r;
      err_nxt     = err;
`endif
      case (state)
         IDLE: begin
            // ack is ignored here; we only get back to IDLE after ack was
            // seen low, so a new req never overlaps the previous ack.
            if (!empty) begin
               pop       = 1'b1;
               data_nxt  = mem[rptr];
               req_nxt   = 1'b1;
               state_nxt = REQ_HI;
`ifdef HS_ACK_TIMEOUT_EN
               wait_nxt    = '0;
               aborted_nxt = 1'b0;
`endif
            end
         end
         REQ_HI: begin
            if (ack) begin
               req_nxt   = 1'b0;
               state_nxt = REQ_LO;
            end
`ifdef HS_ACK_TIMEOUT_EN
            // Abort on the cycle whose increment would make the count reach
            // TIMEOUT, so req is high for exactly TIMEOUT cycles.
            else if (wait_cnt == 8'(TIMEOUT - 1)) begin
               req_nxt     = 1'b0;
               err_nxt     = 1'b1;
               aborted_nxt = 1'b1;
               state_nxt   = REQ_LO;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
            end
`endif
         end
         REQ_LO: begin
            if (!ack) begin
               state_nxt = IDLE;
               if (!aborted) begin
                  done_nxt = 1'b1;
                  cnt_nxt  = xfer_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req      <= 1'b0;
         data_out <= 8'h00;
         done     <= 1'b0;
         xfer_cnt <= 8'h00;
      end else begin
         req      <= req_nxt;
         data_out <= data_nxt;
         done     <= done_nxt;
         xfer_cnt <= cnt_nxt;
      end
   end

`ifdef HS_ACK_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= 8'h00;
         aborted_r <= 1'b0;
         err       <= 1'b0;
      end else begin
         wait_cnt  <= wait_nxt;
         aborted_r <= aborted_nxt;
         err       <= err_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_hs_master_fsm.sv
// Self-checking bench for hs_master_fsm. A randomized slave answers req; a
// queue model of accepted bytes predicts transfer order, FIFO flags and counts.
module tb_hs_master_fsm;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, ack = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, req, busy, done, err;
   logic [7:0] data_out, xfer_cnt;

   always #5 clk = ~clk;

   hs_master_fsm #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .req(req), .data_out(data_out),
      .ack(ack), .busy(busy), .done(done), .xfer_cnt(xfer_cnt), .err(err)
   );

   int checks = 0, failures = 0;
   // model state since last reset
   int acc_cnt, rise_cnt, hs_cnt, done_cnt, abort_n, mon_bad = 0;
   logic err_exp;
   logic [7:0] exp_q[$], got_q[$];
   bit slave_en = 1'b0;

   // Monitor: records each byte offered (req rise) and protocol violations.
   logic req_d = 0, ack_d = 0, done_d = 0;
   logic [7:0] dout_d = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         req_d = 0; ack_d = 0; done_d = 0; dout_d = 0;
      end else begin
         if (req && !req_d) begin
            rise_cnt++;
            got_q.push_back(data_out);
            if (ack) mon_bad++;            // new req while ack still high
         end
         if ((req_d || ack_d) && data_out !== dout_d) mon_bad++;
         if (done) begin
            done_cnt++;
            if (done_d) mon_bad++;         // done longer than one cycle
         end
         req_d = req; ack_d = ack; done_d = done; dout_d = data_out;
      end
   end

   // Slave: random ack delay and random ack-high hold, drops only after req falls.
   int sstate = 0, dly = 0, hold = 0;
   always @(negedge clk) begin
      #1;
      if (!rst_n || !slave_en) begin
         ack = 1'b0; sstate = 0;
      end else begin
         case (sstate)
            0: if (req) begin dly = $urandom_range(2, 0); sstate = 1; end
            1: if (dly == 0) begin ack = 1'b1; hold = $urandom_range(3, 0); sstate = 2; end
               else dly--;
            default: if (hold > 0) hold--;
               else if (!req) begin ack = 1'b0; hs_cnt++; sstate = 0; end
         endcase
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic clear_model();
      acc_cnt = 0; rise_cnt = 0; hs_cnt = 0; done_cnt = 0; abort_n = 0;
      err_exp = 1'b0; exp_q.delete(); got_q.delete();
   endtask

   // Drive one write; the model accepts it iff the FIFO is not full before this edge.
   task automatic push(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      if (acc_cnt - rise_cnt < DEPTH) begin acc_cnt++; exp_q.push_back(b); end
      tick();
      wr_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (hs_cnt != acc_cnt - abort_n && n < 3000) begin tick(); n++; end
      repeat (3) tick();
      checks++;
      if (n >= 3000) begin
         failures++;
         $display("FAIL %s_drain: handshakes=%0d expected=%0d", tag, hs_cnt, acc_cnt - abort_n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; wr_en = 1'b0; slave_en = 1'b0;
      clear_model();
      repeat (2) tick();
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", req); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", data_out); end
      checks++; if (xfer_cnt !== 8'h00) begin failures++; $display("FAIL rst_cnt: got %0d want 0", xfer_cnt); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_done_err: got %b%b want 00", done, err); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL rst_flags: empty=%b full=%b want 1 0", empty, full); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      bit ok;
      slave_en = 1'b1;
      push(8'hA5);
      checks++; if (empty !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL single_lat1: empty=%b req=%b want 0 0", empty, req); end
      tick();
      checks++; if (req !== 1'b1 || data_out !== 8'hA5 || busy !== 1'b1) begin failures++; $display("FAIL single_lat2: req=%b data=%h busy=%b want 1 a5 1", req, data_out, busy); end
      drain("single");
      checks++; if (xfer_cnt !== 8'(hs_cnt) || done_cnt != hs_cnt) begin failures++; $display("FAIL single_cnt: xfer=%0d done=%0d want %0d", xfer_cnt, done_cnt, hs_cnt); end
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && got_q[i] !== exp_q[i]) ok = 0;
      checks++; if (!ok) begin failures++; $display("FAIL single_data: got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_burst();
      bit ok;
      for (int b = 1; b <= 4; b++) push(8'(b));
      drain("burst");
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && got_q[i] !== exp_q[i]) ok = 0;
      checks++; if (!ok) begin failures++; $display("FAIL burst_order: got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
      checks++; if (xfer_cnt !== 8'(hs_cnt)) begin failures++; $display("FAIL burst_cnt: got %0d want %0d", xfer_cnt, 8'(hs_cnt)); end
      checks++; if (empty !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL burst_end: empty=%b busy=%b want 1 0", empty, busy); end
      checks++; if (mon_bad != 0) begin failures++; $display("FAIL burst_protocol: violations=%0d want 0", mon_bad); end
      checks++; if (err !== err_exp) begin failures++; $display("FAIL burst_err: got %b want %b", err, err_exp); end
   endtask

   task automatic test_overflow();
      bit ok;
      slave_en = 1'b0;
      push(8'h10);
      tick();
      checks++; if (req !== 1'b1) begin failures++; $display("FAIL ovf_stuck_req: got %b want 1", req); end
      for (int i = 0; i < 6; i++) begin
         push(8'(8'h20 + i));
         checks++;
         if (full !== (acc_cnt - rise_cnt == DEPTH)) begin
            failures++; $display("FAIL ovf_full_%0d: got %b want %b", i, full, acc_cnt - rise_cnt == DEPTH);
         end
      end
      slave_en = 1'b1;
      drain("ovf");
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && got_q[i] !== exp_q[i]) ok = 0;
      checks++; if (!ok) begin failures++; $display("FAIL ovf_order: got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
      checks++; if (xfer_cnt !== 8'(hs_cnt) || empty !== 1'b1) begin failures++; $display("FAIL ovf_cnt: xfer=%0d empty=%b want %0d 1", xfer_cnt, empty, 8'(hs_cnt)); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      push(8'h77); push(8'h88);
      while (req !== 1'b1 && n < 50) begin tick(); n++; end
      checks++; if (req !== 1'b1) begin failures++; $display("FAIL rmid_req: got %b want 1", req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (req !== 1'b0 || data_out !== 8'h00 || xfer_cnt !== 8'h00) begin
         failures++; $display("FAIL rmid_async: req=%b data=%h cnt=%0d want 0 00 0", req, data_out, xfer_cnt);
      end
      ack = 1'b0;
      clear_model();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      checks++; if (empty !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL rmid_after: empty=%b busy=%b req=%b want 1 0 0", empty, busy, req); end
      checks++; if (done_cnt != 0 || xfer_cnt !== 8'h00) begin failures++; $display("FAIL rmid_nodone: dones=%0d cnt=%0d want 0 0", done_cnt, xfer_cnt); end
   endtask

   task automatic test_wrap();
      bit ok;
      test_reset();
      slave_en = 1'b1;
      while (acc_cnt < 256) begin
         push(8'($urandom));
         if ($urandom_range(3, 0) == 0) tick();
      end
      drain("wrap");
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && got_q[i] !== exp_q[i]) ok = 0;
      checks++; if (!ok) begin failures++; $display("FAIL wrap_order: got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
      checks++; if (xfer_cnt !== 8'(hs_cnt) || done_cnt != hs_cnt) begin failures++; $display("FAIL wrap_cnt: xfer=%0d dones=%0d want %0d %0d", xfer_cnt, done_cnt, 8'(hs_cnt), hs_cnt); end
      checks++; if (mon_bad != 0) begin failures++; $display("FAIL wrap_protocol: violations=%0d want 0", mon_bad); end
   endtask

`ifdef HS_ACK_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0, d0;
      bit ok;
      slave_en = 1'b0;
      d0 = done_cnt;
      push(8'h5A); push(8'h6B);
      while (req !== 1'b1 && n < 50) begin tick(); n++; end
      n = 0;
      while (req === 1'b1 && n < 200) begin tick(); n++; end
      checks++; if (n != TIMEOUT) begin failures++; $display("FAIL to_len: req high %0d cycles want %0d", n, TIMEOUT); end
      abort_n++; err_exp = 1'b1;
      slave_en = 1'b1;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", err); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL to_nodone: dones=%0d want %0d", done_cnt, d0); end
      drain("to");
      ok = (got_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && got_q[i] !== exp_q[i]) ok = 0;
      checks++; if (!ok) begin failures++; $display("FAIL to_order: got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
      checks++; if (xfer_cnt !== 8'(hs_cnt) || err !== err_exp) begin failures++; $display("FAIL to_after: xfer=%0d err=%b want %0d %b", xfer_cnt, err, 8'(hs_cnt), err_exp); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_reset_mid();
      test_wrap();
`ifdef HS_ACK_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
